// File: rtl/seq_issue_ctrl.sv
// In-order single-issue controller: sequences the push/add/mult ALU, owns a 4-entry register
// file and handles the send op through an output handshake. Tolerates same-cycle or late ALU valid.
module seq_issue_ctrl #(
  parameter int unsigned ALU_W   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_inst,
  input  logic             i_inst_valid,
  output logic             o_inst_ready,
  output logic [ALU_W-1:0] o_alu_a,
  output logic [ALU_W-1:0] o_alu_b,
  output logic [1:0]       o_alu_op,
  output logic [3:0]       o_alu_const,
  output logic             o_alu_valid,
  input  logic [ALU_W-1:0] i_alu_data,
  input  logic             i_alu_valid,
  output logic [ALU_W-1:0] o_send_data,
  output logic             o_send_valid,
  input  logic             i_send_ready,
  output logic             o_err,
  output logic [15:0]      o_retired,
  input  logic [1:0]       i_dbg_addr,
  output logic [ALU_W-1:0] o_dbg_data
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] OpPush = 2'b00;
  localparam logic [1:0] OpSend = 2'b11;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StSend} state_t;

  state_t           r_state;
  logic [ALU_W-1:0] r_rf [4];
  logic [1:0]       r_dest;
  logic [CntW-1:0]  r_wait_cnt;

  logic [1:0] w_op;
  logic [1:0] w_ra;
  logic [1:0] w_rb;
  logic       w_is_push;

  assign w_op       = i_inst[7:6];
  assign w_ra       = i_inst[5:4];
  assign w_rb       = i_inst[3:2];
  assign w_is_push  = (w_op == OpPush);
  assign o_dbg_data = r_rf[i_dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_dest       <= '0;
      r_wait_cnt   <= '0;
      o_inst_ready <= 1'b1;
      o_alu_a      <= '0;
      o_alu_b      <= '0;
      o_alu_op     <= '0;
      o_alu_const  <= '0;
      o_alu_valid  <= 1'b0;
      o_send_data  <= '0;
      o_send_valid <= 1'b0;
      o_err        <= 1'b0;
      o_retired    <= '0;
      for (int i = 0; i < 4; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_inst_valid) begin
            o_inst_ready <= 1'b0;
            o_alu_op     <= w_op;
            if (w_op == OpSend) begin
              r_state      <= StSend;
              o_send_valid <= 1'b1;
              o_send_data  <= r_rf[w_ra];
            end else begin
              // Operands captured here stay frozen until the result or timeout.
              r_state     <= StIssue;
              o_alu_valid <= 1'b1;
              o_alu_a     <= r_rf[w_ra];
              o_alu_b     <= w_is_push ? '0 : r_rf[w_rb];
              o_alu_const <= w_is_push ? i_inst[3:0] : 4'd0;
              r_dest      <= w_is_push ? w_ra : i_inst[1:0];
              r_wait_cnt  <= CntW'(1);
            end
          end
        end
        StIssue, StWait: begin
          o_alu_valid <= 1'b0;
          // A result in the final allowed cycle beats the timeout.
          if (i_alu_valid) begin
            r_rf[r_dest] <= i_alu_data;
            o_retired    <= o_retired + 16'd1;
            r_state      <= StIdle;
            o_inst_ready <= 1'b1;
            r_wait_cnt   <= '0;
          end else if (r_wait_cnt == CntW'(TIMEOUT)) begin
            o_err        <= 1'b1;
            r_state      <= StIdle;
            o_inst_ready <= 1'b1;
            r_wait_cnt   <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + CntW'(1);
            r_state    <= StWait;
          end
        end
        StSend: begin
          if (i_send_ready) begin
            o_send_valid <= 1'b0;
            o_retired    <= o_retired + 16'd1;
            r_state      <= StIdle;
            o_inst_ready <= 1'b1;
          end
        end
        default: begin
          r_state      <= StIdle;
          o_inst_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_issue_ctrl.sv
// Directed bench for seq_issue_ctrl: a table of instructions run against a combinational ALU
// stub, then hand sequences for the delayed-ALU, timeout, send-stall and reset-abort cases.
module tb_seq_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i_inst = '0;
  logic        i_inst_valid = 1'b0;
  logic        o_inst_ready;
  logic [7:0]  o_alu_a;
  logic [7:0]  o_alu_b;
  logic [1:0]  o_alu_op;
  logic [3:0]  o_alu_const;
  logic        o_alu_valid;
  logic [7:0]  i_alu_data;
  logic        i_alu_valid;
  logic [7:0]  o_send_data;
  logic        o_send_valid;
  logic        i_send_ready = 1'b0;
  logic        o_err;
  logic [15:0] o_retired;
  logic [1:0]  i_dbg_addr = '0;
  logic [7:0]  o_dbg_data;

  int checks = 0;
  int failures = 0;

  // ALU stub: result valid in cycle valid_cycle counted from ISSUE (=1); 99 means never.
  int          valid_cycle = 1;
  int          cyc = 0;
  int          cur_cyc;
  logic        force_valid = 1'b0;
  logic [15:0] w_prod;

  always #5 clk = ~clk;

  seq_issue_ctrl #(.ALU_W(8), .TIMEOUT(15)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_inst       (i_inst),
    .i_inst_valid (i_inst_valid),
    .o_inst_ready (o_inst_ready),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .o_alu_const  (o_alu_const),
    .o_alu_valid  (o_alu_valid),
    .i_alu_data   (i_alu_data),
    .i_alu_valid  (i_alu_valid),
    .o_send_data  (o_send_data),
    .o_send_valid (o_send_valid),
    .i_send_ready (i_send_ready),
    .o_err        (o_err),
    .o_retired    (o_retired),
    .i_dbg_addr   (i_dbg_addr),
    .o_dbg_data   (o_dbg_data)
  );

  always @(posedge clk) begin
    if (o_inst_ready) cyc <= 0;
    else if (o_alu_valid) cyc <= 2;
    else if (cyc != 0) cyc <= cyc + 1;
  end

  always_comb begin
    cur_cyc = o_alu_valid ? 1 : cyc;
    w_prod  = o_alu_a * o_alu_b;
    case (o_alu_op)
      2'b00:   i_alu_data = {o_alu_a[3:0], o_alu_const};
      2'b01:   i_alu_data = o_alu_a + o_alu_b;
      2'b10:   i_alu_data = w_prod[7:0];
      default: i_alu_data = 8'h00;
    endcase
    if (force_valid) i_alu_data = 8'hEE;
    i_alu_valid = force_valid || ((cur_cyc != 0) && (cur_cyc == valid_cycle));
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rf(input string name, input logic [1:0] addr, input logic [7:0] exp);
    i_dbg_addr = addr;
    #1;
    chk(name, int'(o_dbg_data), int'(exp));
  endtask

  // Issue one instruction and return how many cycles o_inst_ready stayed low.
  task automatic issue(input logic [7:0] inst, output int low);
    @(negedge clk);
    chk("ready_before_issue", int'(o_inst_ready), 1);
    i_inst       = inst;
    i_inst_valid = 1'b1;
    @(negedge clk);
    i_inst_valid = 1'b0;
    low = 0;
    while (!o_inst_ready && low < 40) begin
      low++;
      @(negedge clk);
    end
    if (low >= 40) chk("issue_completion_bound", low, 0);
  endtask

  typedef struct {
    logic [7:0] inst;
    logic [1:0] dst;
    logic [7:0] dst_exp;
    logic [1:0] oth;
    logic [7:0] oth_exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int low;
    int pulses;
    int ret0;
    logic [7:0] a0;
    logic [7:0] b0;

    vecs[0]  = '{8'h05, 2'd0, 8'h05, 2'd1, 8'h00};
    vecs[1]  = '{8'h0A, 2'd0, 8'h5A, 2'd2, 8'h00};
    vecs[2]  = '{8'h0F, 2'd0, 8'hAF, 2'd3, 8'h00};
    vecs[3]  = '{8'h00, 2'd0, 8'hF0, 2'd1, 8'h00};
    vecs[4]  = '{8'h12, 2'd1, 8'h02, 2'd0, 8'hF0};
    vecs[5]  = '{8'h10, 2'd1, 8'h20, 2'd0, 8'hF0};
    vecs[6]  = '{8'h46, 2'd2, 8'h10, 2'd0, 8'hF0};
    vecs[7]  = '{8'h01, 2'd0, 8'h01, 2'd1, 8'h20};
    vecs[8]  = '{8'h02, 2'd0, 8'h12, 2'd2, 8'h10};
    vecs[9]  = '{8'h11, 2'd1, 8'h01, 2'd0, 8'h12};
    vecs[10] = '{8'h10, 2'd1, 8'h10, 2'd2, 8'h10};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_inst_ready", int'(o_inst_ready), 1);
    chk("rst_alu_valid", int'(o_alu_valid), 0);
    chk("rst_send_valid", int'(o_send_valid), 0);
    chk("rst_err", int'(o_err), 0);
    chk("rst_retired", int'(o_retired), 0);
    chk("rst_alu_a", int'(o_alu_a), 0);
    chk_rf("rst_rf3", 2'd3, 8'h00);

    // Combinational ALU table: push build-up and add with wrap.
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].inst, low);
      chk("tbl_ready_low_cycles", low, 1);
      chk("tbl_retired", int'(o_retired), i + 1);
      chk_rf("tbl_dst", vecs[i].dst, vecs[i].dst_exp);
      chk_rf("tbl_other", vecs[i].oth, vecs[i].oth_exp);
    end

    // Delayed ALU: valid in cycle 4, mult r0*r1 -> r3.
    valid_cycle = 4;
    ret0 = int'(o_retired);
    @(negedge clk);
    i_inst = 8'h87;
    i_inst_valid = 1'b1;
    @(negedge clk);
    i_inst_valid = 1'b0;
    a0 = o_alu_a;
    b0 = o_alu_b;
    chk("mult_a", int'(a0), 8'h12);
    chk("mult_b", int'(b0), 8'h10);
    pulses = 0;
    for (int k = 1; k <= 4; k++) begin
      if (o_alu_valid) pulses++;
      chk("mult_a_stable", int'(o_alu_a), 8'h12);
      chk("mult_b_stable", int'(o_alu_b), 8'h10);
      chk("mult_busy", int'(o_inst_ready), 0);
      @(negedge clk);
    end
    chk("mult_pulses", pulses, 1);
    chk("mult_done_ready", int'(o_inst_ready), 1);
    chk("mult_retired", int'(o_retired), ret0 + 1);
    chk_rf("mult_r3", 2'd3, 8'h20);

    // Timeout: ALU never answers; add r0,r1 -> r2 must leave r2 alone.
    valid_cycle = 99;
    ret0 = int'(o_retired);
    issue(8'h46, low);
    chk("to_cycles", low, 15);
    chk("to_err", int'(o_err), 1);
    chk("to_retired", int'(o_retired), ret0);
    chk("to_ready", int'(o_inst_ready), 1);
    chk_rf("to_r2_kept", 2'd2, 8'h10);

    // Valid in cycle 15 wins over timeout (fresh reset clears sticky err).
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    valid_cycle = 1;
    issue(8'h03, low);
    issue(8'h14, low);
    valid_cycle = 15;
    issue(8'h46, low);
    chk("late_cycles", low, 15);
    chk("late_err", int'(o_err), 0);
    chk("late_retired", int'(o_retired), 3);
    chk_rf("late_r2", 2'd2, 8'h07);

    // Send stalled for 5 cycles.
    valid_cycle = 1;
    issue(8'h05, low);
    issue(8'h0A, low);
    chk_rf("send_src", 2'd0, 8'h5A);
    ret0 = int'(o_retired);
    @(negedge clk);
    i_inst = 8'hC0;
    i_inst_valid = 1'b1;
    @(negedge clk);
    i_inst_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      chk("send_valid", int'(o_send_valid), 1);
      chk("send_data", int'(o_send_data), 8'h5A);
      chk("send_alu_idle", int'(o_alu_valid), 0);
      if (k == 6) i_send_ready = 1'b1;
      @(negedge clk);
    end
    i_send_ready = 1'b0;
    chk("send_done_valid", int'(o_send_valid), 0);
    chk("send_done_ready", int'(o_inst_ready), 1);
    chk("send_retired", int'(o_retired), ret0 + 1);

    // Reset during WAIT, then a stray ALU valid.
    valid_cycle = 99;
    @(negedge clk);
    i_inst = 8'h46;
    i_inst_valid = 1'b1;
    @(negedge clk);
    i_inst_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_wait", int'(o_inst_ready), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    force_valid = 1'b1;
    @(negedge clk);
    force_valid = 1'b0;
    @(negedge clk);
    chk("abort_ready", int'(o_inst_ready), 1);
    chk("abort_alu_valid", int'(o_alu_valid), 0);
    chk("abort_retired", int'(o_retired), 0);
    chk("abort_err", int'(o_err), 0);
    for (int r = 0; r < 4; r++) chk_rf("abort_rf", 2'(r), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_issue_ctrl.md
Name: seq_issue_ctrl

Overview:
In-order, single-issue controller that sequences the sequencer ALU (push/add/mult) and owns the 4-entry, ALU_W-bit register file.
- Accepts 8-bit instructions over a valid/ready handshake.
- Reads operands and drives the ALU request interface, then waits for the ALU's valid.
- Writes the result back, and handles the send op through an output handshake.
- Tolerates both combinational ALUs (same-cycle valid) and pipelined ALUs (delayed valid), with a watchdog timeout.

Parameters:
ALU_W, 8, ALU data width and register width.
TIMEOUT, 15, maximum cycles from ISSUE (counted as cycle 1) to i_alu_valid.

Ports:
clk  in  1  clock; single clock domain.
rst  in  1  synchronous, active-high reset.
i_inst  in  8  instruction: [7:6] op, [5:4] ra, [3:2] rb, [1:0] rd; push uses ra as destination and [3:0] as imm.
i_inst_valid  in  1  instruction valid.
o_inst_ready  out  1  controller can accept an instruction.
o_alu_a  out  ALU_W  operand A.
o_alu_b  out  ALU_W  operand B.
o_alu_op  out  2  op to ALU.
o_alu_const  out  4  immediate to ALU.
o_alu_valid  out  1  one-cycle request pulse.
i_alu_data  in  ALU_W  ALU result.
i_alu_valid  in  1  ALU result valid.
o_send_data  out  ALU_W  send payload.
o_send_valid  out  1  send valid.
i_send_ready  in  1  send consumer ready.
o_err  out  1  sticky ALU timeout flag.
o_retired  out  16  count of retired instructions; wraps 0xFFFF->0.
i_dbg_addr  in  2  register readback address.
o_dbg_data  out  ALU_W  rf[i_dbg_addr], combinational.

Behaviour:
- Op encoding: push=00, add=01, mult=10, send=11. These equal the shared seq_op_* constants.
- Reset values: all outputs 0 except o_inst_ready=1. rf, o_err, o_retired and the wait counter are all 0; state=IDLE.
- Reset mid-operation: aborts immediately. No writeback occurs, and a late i_alu_valid is ignored.
- FSM states: IDLE, ISSUE, WAIT, SEND.
- IDLE:
  - o_inst_ready=1.
  - On i_inst_valid&&o_inst_ready, latch i_inst.
  - Next state is SEND if op=11, otherwise ISSUE.
- ISSUE (exactly 1 cycle):
  - o_alu_valid=1.
  - Operands are registered from rf, then held constant through WAIT:
    - push: a=rf[ra], const=inst[3:0].
    - add/mult: a=rf[ra], b=rf[rb].
  - If i_alu_valid=1 in this cycle: rf[dest] <= i_alu_data, o_retired++, next state IDLE. Otherwise next state WAIT.
  - Combinational-ALU throughput is therefore 1 instruction per 2 cycles.
- WAIT:
  - o_alu_valid=0; operands stable.
  - On i_alu_valid: write back, o_retired++, next state IDLE.
- Destination: ra for push, rd for add/mult. Result width is taken as delivered; the ALU truncates to ALU_W and the controller does not extend it.
- Timeout:
  - If no i_alu_valid has been seen by the end of cycle TIMEOUT (ISSUE = cycle 1): o_err<=1, no write, no count, next state IDLE.
  - i_alu_valid arriving in cycle TIMEOUT itself is accepted; valid wins over timeout.
  - o_err stays high until rst; the controller keeps operating.
- SEND:
  - o_send_valid=1; o_send_data=rf[ra] captured on entry and stable while stalled.
  - On i_send_ready: o_retired++, next state IDLE. Ready in the first SEND cycle completes in 1 cycle.
  - The ALU is not touched.
- Write/read collision: o_dbg_data shows the old value in the write cycle and the new value the following cycle.
- o_inst_ready=0 in every state other than IDLE; there is no instruction buffering.

Test Plan:
1. After rst, push ra=0 imm=5, then push ra=0 imm=A, with a combinational ALU stub -> rf[0]=0x5A, o_retired=2. o_inst_ready is low for exactly 1 cycle after each accept.
2. rf[0]=0xF0, rf[1]=0x20, add ra=0 rb=1 rd=2 -> rf[2]=0x10 (wrap); rf[0] and rf[1] unchanged.
3. Stub delays i_alu_valid 3 cycles after ISSUE; rf[0]=0x12, rf[1]=0x10, mult rd=3 -> rf[3]=0x20.
   - o_alu_valid pulses once.
   - o_alu_a and o_alu_b stay stable for all 4 cycles.
4. Stub never asserts valid, TIMEOUT=15 -> o_err rises at the end of cycle 15 and rd is unchanged. o_retired is unchanged and o_inst_ready=1 the next cycle.
   - Repeat with valid in cycle 15 -> write occurs, o_err stays 0.
5. send ra=0 (0x5A) with i_send_ready low for 5 cycles -> o_send_valid=1 and data 0x5A held for 6 cycles. Completes on ready, o_retired+1.
6. rst asserted during WAIT, stub asserts valid 1 cycle after rst -> state IDLE, o_alu_valid=0, all rf=0, o_retired=0, no write.
